// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one shared borrow cell reused WIDTH times.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_borrow;

  logic [WIDTH-1:0] w_part_next;
  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_br_next;
  logic             w_load;
  logic             w_run;
  logic             w_last;

  // Shared bit-cell: one full-subtractor step per clock
  assign w_ai      = r_a[0];
  assign w_bi      = r_b[0];
  assign w_d       = w_ai ^ w_bi ^ r_br;
  assign w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);

  generate
    if (WIDTH == 1) begin : g_w1
      assign w_part_next = w_d;
    end else begin : g_wn
      assign w_part_next = {w_d, r_part[WIDTH-1:1]};
    end
  endgenerate

  assign w_load = (r_state == S_IDLE) & in_valid;
  assign w_run  = (r_state == S_RUN);
  assign w_last = w_run & (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (r_state == S_IDLE): in_ready  = 1'b1;
      (r_state == S_DONE): out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_part   <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      if (w_load) begin
        r_a    <= a;
        r_b    <= b;
        r_part <= '0;
        r_br   <= 1'b0;
        r_cnt  <= '0;
      end else if (w_run) begin
        r_a    <= r_a >> 1;
        r_b    <= r_b >> 1;
        r_part <= w_part_next;
        r_br   <= w_br_next;
        r_cnt  <= r_cnt + CW'(1);
      end
      // Result registers only change on completion
      if (w_last) begin
        r_diff   <= w_part_next;
        r_borrow <= w_br_next;
      end
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;

`ifdef SERIAL_SUB_OVF_EN
  logic r_amsb;
  logic r_bmsb;
  logic r_ovf;

  // Operand MSBs are kept since the shift registers lose them
  always_ff @(posedge clk) begin
    if (rst) begin
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_load) begin
        r_amsb <= a[WIDTH-1];
        r_bmsb <= b[WIDTH-1];
      end
      if (w_last) begin
        r_ovf <= (r_amsb ^ r_bmsb) & (r_amsb ^ w_part_next[WIDTH-1]);
      end
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor, WIDTH=8.
// Random and directed operands checked against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] m_diff(input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    return x - y;
  endfunction

  function automatic logic m_borrow(input logic [W-1:0] x,
                                    input logic [W-1:0] y);
    return x < y;
  endfunction

  function automatic logic m_ovf(input logic [W-1:0] x,
                                 input logic [W-1:0] y);
    int sx;
    int sy;
    int d;
    sx = $signed(x);
    sy = $signed(y);
    d  = sx - sy;
    return (d > (2 ** (W - 1)) - 1) || (d < -(2 ** (W - 1)));
  endfunction

  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_wait", 32'(in_ready), 1);
  endtask

  // One operation; hold = cycles out_ready stays low after out_valid
  task automatic do_op(input logic [W-1:0] va,
                       input logic [W-1:0] vb,
                       input int hold);
    int k;
    logic [W-1:0] ed;
    logic eb;
    ed = m_diff(va, vb);
    eb = m_borrow(va, vb);
    wait_ready();
    in_valid  = 1'b1;
    a         = va;
    b         = vb;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    k = 0;
    // Negedge k follows edge E0+k-1, so out_valid first seen at k=W+1
    do begin
      @(negedge clk);
      k++;
      if (k == 2) chk("run_in_ready", 32'(in_ready), 0);
      if (!out_valid) begin
        in_valid = 1'($urandom);
        a = 8'($urandom);
        b = 8'($urandom);
      end
    end while (!out_valid && k < 40);
    in_valid = 1'b0;
    chk("latency", 32'(k), 32'(W + 1));
    chk("diff", 32'(diff), 32'(ed));
    chk("borrow", 32'(borrow), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    chk("ovf", 32'(ovf), 32'(m_ovf(va, vb)));
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 1);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_diff", 32'(diff), 32'(ed));
      chk("hold_borrow", 32'(borrow), 32'(eb));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("out_valid_fall", 32'(out_valid), 0);
    chk("in_ready_back", 32'(in_ready), 1);
    chk("diff_kept", 32'(diff), 32'(ed));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_borrow", 32'(borrow), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    do_op(8'h35, 8'h12, 0);
    do_op(8'h12, 8'h35, 0);
    do_op(8'h00, 8'h01, 0);
    do_op(8'hA5, 8'hA5, 0);
    do_op(8'h00, 8'hFF, 0);
    do_op(8'h80, 8'h01, 0);
    do_op(8'h7F, 8'hFF, 0);
    do_op(8'h10, 8'h05, 0);

    do_op(8'h9C, 8'h3B, 5);

    // Reset sampled at the edge ending the 4th RUN cycle
    wait_ready();
    in_valid = 1'b1;
    a = 8'h44;
    b = 8'h11;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_diff", 32'(diff), 0);
    chk("midrst_borrow", 32'(borrow), 0);
    repeat (W + 2) begin
      @(negedge clk);
      chk("midrst_no_result", 32'(out_valid), 0);
    end
    do_op(8'hF0, 8'h0F, 0);

    begin : b2b
      logic [W-1:0] ed_q[$];
      logic         eb_q[$];
      int pushed;
      int got;
      int cyc;
      int last;
      pushed = 1;
      got    = 0;
      cyc    = 0;
      last   = -1;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      a = 8'($urandom);
      b = 8'($urandom);
      ed_q.push_back(m_diff(a, b));
      eb_q.push_back(m_borrow(a, b));
      while (got < 3 && cyc < 100) begin
        @(negedge clk);
        cyc++;
        if (out_valid) begin
          chk("b2b_diff", 32'(diff), 32'(ed_q.pop_front()));
          chk("b2b_borrow", 32'(borrow), 32'(eb_q.pop_front()));
          if (last >= 0) chk("b2b_gap", 32'(cyc - last), 32'(W + 2));
          last = cyc;
          got++;
        end
        if (in_ready) begin
          if (pushed < 3) begin
            a = 8'($urandom);
            b = 8'($urandom);
            ed_q.push_back(m_diff(a, b));
            eb_q.push_back(m_borrow(a, b));
            pushed++;
          end else begin
            in_valid = 1'b0;
          end
        end
      end
      in_valid = 1'b0;
      chk("b2b_count", 32'(got), 3);
      @(negedge clk);
      chk("b2b_idle", 32'(in_ready), 1);
    end

    for (int i = 0; i < 20; i++) begin
      do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
